serial_add_wide: RTL and testbench

SERIAL_ADD_WIDE -- requirements
Module: serial_add_wide

---
 rtl/serial_add_wide_pkg.sv | 13 +
 rtl/serial_add_wide_if.sv | 48 ++++
 rtl/serial_add_wide_byte_add8.sv | 44 ++++
 rtl/serial_add_wide.sv | 85 ++++++++
 tb/tb_serial_add_wide.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/serial_add_wide_pkg.sv
// Shared types and constants for the byte-serial wide adder.
// Holds the FSM state encoding and the byte width.
package serial_add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_wide_if.sv
// Operand/result handshake bundle for serial_add_wide.
// slave is the adder's view, master is the driver's view.
interface serial_add_wide_if
  import serial_add_pkg::*;
#(
  parameter int NUM_BYTES = 4
);

  localparam int W = BYTE_W * NUM_BYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout,
    output busy
  );

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout,
    input  busy
  );

endinterface

// File: rtl/serial_add_wide_byte_add8.sv
// Combinational 8-bit carry-lookahead adder.
// Each carry is a flat sum of generate terms gated by propagate runs.
module byte_add8
  import serial_add_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              cin_i,
  output logic [BYTE_W-1:0] sum_o,
  output logic              cout_o
);

  logic [BYTE_W-1:0] g;
  logic [BYTE_W-1:0] p;
  logic [BYTE_W:0]   c;

  function automatic logic [BYTE_W:0] cla(
    input logic [BYTE_W-1:0] gi,
    input logic [BYTE_W-1:0] pi,
    input logic              c0
  );
    logic [BYTE_W:0] cc;
    logic            pp;
    cc    = '0;
    cc[0] = c0;
    for (int i = 0; i < BYTE_W; i++) begin
      cc[i+1] = gi[i];
      pp      = pi[i];
      for (int j = i - 1; j >= 0; j--) begin
        cc[i+1] = cc[i+1] | (pp & gi[j]);
        pp      = pp & pi[j];
      end
      cc[i+1] = cc[i+1] | (pp & c0);
    end
    return cc;
  endfunction

  assign g      = a_i & b_i;
  assign p      = a_i ^ b_i;
  assign c      = cla(g, p, cin_i);
  assign sum_o  = p ^ c[BYTE_W-1:0];
  assign cout_o = c[BYTE_W];

endmodule

// File: rtl/serial_add_wide.sv
// Byte-serial wide adder: one byte per cycle through a shared CLA byte adder.
// Result is held in DONE until the consumer takes it.
module serial_add_wide
  import serial_add_pkg::*;
#(
  parameter int NUM_BYTES = 4
)(
  input  logic            clk,
  input  logic            rst,
  serial_add_wide_if.slave io
);

  localparam int IW = $clog2(NUM_BYTES);
  localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);

  typedef logic [NUM_BYTES-1:0][BYTE_W-1:0] bytes_t;

  state_e        state_q;
  bytes_t        a_q;
  bytes_t        b_q;
  bytes_t        sum_q;
  logic          carry_q;
  logic          cout_q;
  logic [IW-1:0] idx_q;

  logic [BYTE_W-1:0] byte_sum_d;
  logic              byte_cout_d;

  byte_add8 u_add (
    .a_i    (a_q[idx_q]),
    .b_i    (b_q[idx_q]),
    .cin_i  (carry_q),
    .sum_o  (byte_sum_d),
    .cout_o (byte_cout_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (io.in_valid) begin
            a_q     <= io.a;
            b_q     <= io.b;
            carry_q <= io.cin;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // carry threads byte to byte through carry_q only
          sum_q[idx_q] <= byte_sum_d;
          carry_q      <= byte_cout_d;
          idx_q        <= idx_q + IW'(1);
          if (idx_q == LAST) begin
            cout_q  <= byte_cout_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.busy      = (state_q != IDLE);
  assign io.sum       = sum_q;
  assign io.cout      = cout_q;

endmodule

// File: tb/tb_serial_add_wide.sv
// Directed and random checks of serial_add_wide at 4 and 2 bytes.
// Expected results come from plain wide arithmetic.
module tb_serial_add_wide;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ncmp = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  serial_add_wide_if #(.NUM_BYTES(4)) io4 ();
  serial_add_wide_if #(.NUM_BYTES(2)) io2 ();

  serial_add_wide #(.NUM_BYTES(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .io  (io4)
  );

  serial_add_wide #(.NUM_BYTES(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .io  (io2)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add4(input logic [31:0] a, input logic [31:0] b,
                      input logic c, input int hold);
    logic [32:0] exp;
    logic [7:0]  b0;
    int          n;
    exp = {1'b0, a} + {1'b0, b} + 33'(c);
    b0  = 8'(a[7:0] + b[7:0] + 8'(c));
    n = 0;
    while (!io4.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("wait_ready4", 64'(io4.in_ready), 64'd1);
    io4.a = a;
    io4.b = b;
    io4.cin = c;
    io4.in_valid = 1'b1;
    io4.out_ready = (hold == 0);
    tick();
    io4.in_valid = 1'b0;
    n = 0;
    while (!io4.out_valid && n < 50) begin
      tick();
      n++;
      if (n == 1) begin
        check("part_sum4", 64'(io4.sum), 64'(b0));
        check("run_ready4", 64'({io4.in_ready, io4.busy}), 64'b01);
      end
    end
    check("lat4", 64'(n), 64'd4);
    check("sum4", 64'({io4.cout, io4.sum}), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold4", 64'({io4.out_valid, io4.in_ready, io4.cout, io4.sum}),
            64'({2'b10, exp}));
    end
    io4.out_ready = 1'b1;
    tick();
    check("release4", 64'({io4.out_valid, io4.in_ready, io4.busy}), 64'b010);
    io4.out_ready = 1'b0;
  endtask

  task automatic add2(input logic [15:0] a, input logic [15:0] b,
                      input logic c);
    logic [16:0] exp;
    int          n;
    exp = {1'b0, a} + {1'b0, b} + 17'(c);
    io2.a = a;
    io2.b = b;
    io2.cin = c;
    io2.in_valid = 1'b1;
    io2.out_ready = 1'b1;
    tick();
    io2.in_valid = 1'b0;
    n = 0;
    while (!io2.out_valid && n < 50) begin
      tick();
      n++;
    end
    check("lat2", 64'(n), 64'd2);
    check("sum2", 64'({io2.cout, io2.sum}), 64'(exp));
    tick();
    check("release2", 64'({io2.out_valid, io2.in_ready}), 64'b01);
  endtask

  initial begin
    logic [32:0] expq[$];
    int          accq[$];
    int          cyc;
    int          nres;
    int          n;
    io4.in_valid = 1'b0;
    io4.a = '0;
    io4.b = '0;
    io4.cin = 1'b0;
    io4.out_ready = 1'b0;
    io2.in_valid = 1'b0;
    io2.a = '0;
    io2.b = '0;
    io2.cin = 1'b0;
    io2.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst4", 64'({io4.in_ready, io4.out_valid, io4.busy,
                       io4.cout, io4.sum}), {28'd0, 4'b1000, 32'd0});
    check("rst2", 64'({io2.in_ready, io2.out_valid, io2.busy,
                       io2.cout, io2.sum}), {44'd0, 4'b1000, 16'd0});

    add4(32'h12345678, 32'h11111111, 1'b0, 0);
    add4(32'hFFFFFFFF, 32'h00000000, 1'b1, 0);
    add4(32'h80000000, 32'h80000000, 1'b0, 10);

    // reset during the second RUN cycle
    io4.a = 32'hDEADBEEF;
    io4.b = 32'h01010101;
    io4.in_valid = 1'b1;
    io4.out_ready = 1'b1;
    tick();
    io4.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort", 64'({io4.in_ready, io4.out_valid, io4.busy,
                        io4.cout, io4.sum}), {28'd0, 4'b1000, 32'd0});
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n += int'(io4.out_valid);
    end
    check("no_partial", 64'(n), 64'd0);
    add4(32'h00000001, 32'h00000001, 1'b0, 0);

    // in_valid held high with changing operands
    io4.out_ready = 1'b1;
    cyc = 0;
    nres = 0;
    while (nres < 2 && cyc < 60) begin
      io4.a = $urandom;
      io4.b = $urandom;
      io4.cin = 1'($urandom);
      io4.in_valid = 1'b1;
      if (io4.in_ready) begin
        expq.push_back({1'b0, io4.a} + {1'b0, io4.b} + 33'(io4.cin));
        accq.push_back(cyc);
      end
      tick();
      cyc++;
      if (io4.out_valid) begin
        check("held_sum", 64'({io4.cout, io4.sum}),
              64'(expq.size() > 0 ? expq.pop_front() : 33'h0));
        nres++;
      end
    end
    io4.in_valid = 1'b0;
    check("held_results", 64'(nres), 64'd2);
    check("accept_gap",
          64'(accq.size() > 1 ? accq[1] - accq[0] : 0), 64'd6);
    tick();
    tick();

    for (int i = 0; i < 3000; i++) begin
      add4($urandom, $urandom, 1'($urandom), 0);
    end
    for (int i = 0; i < 3000; i++) begin
      add2(16'($urandom), 16'($urandom), 1'($urandom));
    end
    add2(16'hFFFF, 16'h0000, 1'b1);
    add2(16'hFFFF, 16'hFFFF, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
